hpdcache_sram_1rw_banked: RTL and testbench



---
 rtl/hpdcache_sram_1rw_banked.sv | 171 +++++++++++++++++
 tb/tb_hpdcache_sram_1rw_banked.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_sram_1rw_banked.sv
// Banked single-port SRAM wrapper for hpdcache arrays: per-byte write enables,
// optional registered read data and a hardware clear sequencer.

module la_spram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          we,
  input  logic [DW-1:0] wmask,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem[addr] <= (mem[addr] & ~wmask) | (din & wmask);
      else    dout      <= mem[addr];
    end
  end
endmodule

module hpdcache_sram_1rw_banked #(
  parameter int ADDR_SIZE     = 8,
  parameter int DATA_SIZE     = 64,
  parameter int NBANKS        = 2,
  parameter int OUT_REG       = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  output logic                   ready,
  input  logic                   cs,
  input  logic                   we,
  input  logic [ADDR_SIZE-1:0]   addr,
  input  logic [DATA_SIZE/8-1:0] wbyteenable,
  input  logic [DATA_SIZE-1:0]   wdata,
  output logic [DATA_SIZE-1:0]   rdata,
  output logic                   rvalid
);
  localparam int BSEL_W     = $clog2(NBANKS);
  localparam int BANK_AW    = ADDR_SIZE - BSEL_W;
  localparam int BANK_DEPTH = 2**BANK_AW;
  localparam int BE_W       = DATA_SIZE/8;
  // Degenerate widths (one bank, or one word per bank) are widened to 1 bit and tied off.
  localparam int SEL_W      = (BSEL_W > 0) ? BSEL_W : 1;
  localparam int BA_W       = (BANK_AW > 0) ? BANK_AW : 1;

  typedef enum logic {IDLE, INIT} state_t;

  state_t                 state, state_next;
  logic [BA_W-1:0]        cnt;
  logic                   last_clear;
  logic                   accept;
  logic [SEL_W-1:0]       bsel, rd_bsel;
  logic                   rd_v;
  logic [BA_W-1:0]        req_addr;
  logic [DATA_SIZE-1:0]   req_wmask;
  logic [NBANKS-1:0]      bank_ce;
  logic                   bank_we;
  logic [BA_W-1:0]        bank_addr;
  logic [DATA_SIZE-1:0]   bank_wmask, bank_din;
  logic [DATA_SIZE-1:0]   dout [NBANKS];
  logic [DATA_SIZE-1:0]   rd_dout;

  assign ready      = (state == IDLE);
  assign accept     = cs && ready;
  assign last_clear = (cnt == BA_W'(BANK_DEPTH - 1));
  assign bsel       = (NBANKS > 1) ? addr[ADDR_SIZE-1 -: SEL_W] : '0;
  assign req_addr   = (BANK_AW > 0) ? addr[BA_W-1:0] : '0;

  always_comb begin
    req_wmask = '0;
    for (int unsigned b = 0; b < BE_W; b++)
      req_wmask[b*8 +: 8] = {8{wbyteenable[b]}};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (flush) state_next = INIT;
      INIT:    if (last_clear) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (INIT_ON_RESET != 0) ? INIT : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) cnt <= last_clear ? '0 : cnt + 1'b1;
    end
  end

  // During the clear every bank writes zero at the same counter address.
  always_comb begin
    bank_ce    = '0;
    bank_we    = we;
    bank_addr  = req_addr;
    bank_wmask = req_wmask;
    bank_din   = wdata;
    if (state == INIT) begin
      bank_ce    = '1;
      bank_we    = 1'b1;
      bank_addr  = cnt;
      bank_wmask = '1;
      bank_din   = '0;
    end else begin
      for (int unsigned i = 0; i < NBANKS; i++)
        bank_ce[i] = accept && (bsel == SEL_W'(i));
    end
  end

  for (genvar i = 0; i < NBANKS; i++) begin : g_bank
    la_spram #(.DW(DATA_SIZE), .AW(BA_W)) u_ram (
      .clk   (clk),
      .ce    (bank_ce[i]),
      .we    (bank_we),
      .wmask (bank_wmask),
      .addr  (bank_addr),
      .din   (bank_din),
      .dout  (dout[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v    <= 1'b0;
      rd_bsel <= '0;
    end else begin
      rd_v <= accept && !we;
      if (accept && !we) rd_bsel <= bsel;
    end
  end

  always_comb begin
    rd_dout = '0;
    for (int unsigned i = 0; i < NBANKS; i++)
      if (rd_bsel == SEL_W'(i)) rd_dout = dout[i];
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                 rv_q;
    logic [DATA_SIZE-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv_q    <= 1'b0;
        rdata_q <= '0;
      end else begin
        rv_q <= rd_v;
        if (rd_v) rdata_q <= rd_dout;
      end
    end
    assign rvalid = rv_q;
    assign rdata  = rdata_q;
  end else begin : g_noreg
    logic [DATA_SIZE-1:0] hold_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    hold_q <= '0;
      else if (rd_v) hold_q <= rd_dout;
    end
    assign rvalid = rd_v;
    assign rdata  = rd_v ? rd_dout : hold_q;
  end
endmodule

// File: tb/tb_hpdcache_sram_1rw_banked.sv
// Scoreboard bench: two instances (combinational and registered read data)
// share one stimulus stream; a reference memory predicts every read.

module tb_hpdcache_sram_1rw_banked;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, cs, we;
  logic [7:0]  addr;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic        ready0, ready1, rvalid0, rvalid1;
  logic [63:0] rdata0, rdata1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n;

  typedef struct { logic [63:0] data; int c0; } exp_t;
  exp_t        q0[$], q1[$];
  logic [63:0] last0 = '0, last1 = '0;
  logic [63:0] mem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hpdcache_sram_1rw_banked #(.ADDR_SIZE(8), .DATA_SIZE(64), .NBANKS(2), .OUT_REG(0), .INIT_ON_RESET(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready0), .cs(cs), .we(we), .addr(addr),
    .wbyteenable(be), .wdata(wdata), .rdata(rdata0), .rvalid(rvalid0));

  hpdcache_sram_1rw_banked #(.ADDR_SIZE(8), .DATA_SIZE(64), .NBANKS(2), .OUT_REG(1), .INIT_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready1), .cs(cs), .we(we), .addr(addr),
    .wbyteenable(be), .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_rvalid0", {63'd0, rvalid0}, 64'd0);
      check("rst_rvalid1", {63'd0, rvalid1}, 64'd0);
      check("rst_rdata0", rdata0, 64'd0);
      check("rst_rdata1", rdata1, 64'd0);
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0;
    end else begin
      if (rvalid0) begin
        if (q0.size() == 0) check("spurious0", {63'd0, rvalid0}, 64'd0);
        else begin
          e = q0.pop_front();
          check("data0", rdata0, e.data);
          check("lat0", 64'(cyc - e.c0), 64'd1);
          last0 = e.data;
        end
      end else check("hold0", rdata0, last0);
      if (rvalid1) begin
        if (q1.size() == 0) check("spurious1", {63'd0, rvalid1}, 64'd0);
        else begin
          e = q1.pop_front();
          check("data1", rdata1, e.data);
          check("lat1", 64'(cyc - e.c0), 64'd2);
          last1 = e.data;
        end
      end else check("hold1", rdata1, last1);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic idle(input int cycles);
    cs = 1'b0; we = 1'b0;
    repeat (cycles) tick();
  endtask

  task automatic rd(input logic [7:0] a);
    cs = 1'b1; we = 1'b0; addr = a;
    q0.push_back('{data: mem[a], c0: cyc});
    q1.push_back('{data: mem[a], c0: cyc});
    tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d, input logic [7:0] m);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d; be = m;
    for (int b = 0; b < 8; b++)
      if (m[b]) mem[a][b*8 +: 8] = d[b*8 +: 8];
    tick();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  // Counts clock edges until ready rises; optional in-clear disturbances.
  task automatic wait_clear(input int flush_at, input int wr_at, input int rst_at, output int cnt);
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      cs = 1'b0; flush = 1'b0;
      cnt++;
      if (ready0) break;
      if (cnt == flush_at) flush = 1'b1;
      if (cnt == wr_at) begin
        cs = 1'b1; we = 1'b1; addr = 8'h20; wdata = '1; be = '1;
      end
      if (cnt == wr_at + 1) begin
        cs = 1'b1; we = 1'b0; addr = 8'h20;
      end
      if (cnt == rst_at) begin
        rst_n = 1'b0;
        return;
      end
    end
    cs = 1'b0; we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; cs = 1'b0; we = 1'b0;
    addr = '0; be = '0; wdata = '0;
    clear_model();
    repeat (3) tick();
    rst_n = 1'b1;
    check("ready_after_rst", {63'd0, ready0}, 64'd0);
    wait_clear(-1, -100, -1, n);
    check("init_len", 64'(n), 64'd128);
    check("ready1_up", {63'd0, ready1}, 64'd1);

    rd(8'h00); rd(8'h7F); rd(8'h80); rd(8'hFF);
    idle(3);

    wr(8'h05, 64'h1122334455667788, 8'hFF);
    wr(8'h05, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    rd(8'h05);
    idle(3);
    wr(8'h05, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    rd(8'h05);
    idle(3);

    wr(8'h10, 64'hA, 8'hFF);
    wr(8'h90, 64'hB, 8'hFF);
    rd(8'h10); rd(8'h90);
    wr(8'h11, 64'hC, 8'hFF);
    idle(4);

    // Read accepted in the flush cycle still returns pre-clear data.
    wr(8'h03, 64'h5, 8'hFF);
    cs = 1'b1; we = 1'b0; addr = 8'h03; flush = 1'b1;
    q0.push_back('{data: mem[8'h03], c0: cyc});
    q1.push_back('{data: mem[8'h03], c0: cyc});
    clear_model();
    tick();
    cs = 1'b0; flush = 1'b0;
    wait_clear(50, -100, -1, n);
    check("flush_len", 64'(n), 64'd128);
    rd(8'h03);
    idle(3);

    wr(8'h07, 64'hDEAD, 8'hFF);
    rd(8'h07);
    idle(2);
    flush = 1'b1; clear_model(); tick(); flush = 1'b0;
    wait_clear(-1, 60, -1, n);
    check("flush2_len", 64'(n), 64'd128);
    rd(8'h20);
    idle(3);

    wr(8'h07, 64'hBEEF, 8'hFF);
    rd(8'h07);
    idle(2);
    flush = 1'b1; clear_model(); tick(); flush = 1'b0;
    wait_clear(-1, -100, 40, n);
    check("rst_at_cnt", 64'(n), 64'd40);
    @(negedge clk);
    check("midrst_rdata0", rdata0, 64'd0);
    check("midrst_ready0", {63'd0, ready0}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_clear(-1, -100, -1, n);
    check("restart_len", 64'(n), 64'd128);
    rd(8'h07);
    idle(4);

    check("q0_empty", 64'(q0.size()), 64'd0);
    check("q1_empty", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
